multicycle_mem_bridge: RTL and testbench

Sits directly downstream of the multicycle controller, between its memory strobes (mem_read_enable, mem_write_enable, inst_or_data) and a variable-latency valid/ready memory bus. It converts each single-cycle controller memory access into a bus transaction with a request and response phase. It returns a stall to the controller until the access completes. For data accesses it generates byte strobes and lane-aligned write data, and sign- or zero-extends load data.

---
 rtl/multicycle_mem_bridge_if.sv | 35 +++
 rtl/multicycle_mem_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_mem_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_mem_bridge_if.sv
// Memory bus between the multicycle bridge (master) and a variable-latency
// memory (slave): a valid/ready request phase followed, for reads, by a
// response phase with no back-pressure.
interface multicycle_mem_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_strobe;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  modport master (
    output bus_req_valid,
    output bus_req_write,
    output bus_req_addr,
    output bus_req_wdata,
    output bus_req_strobe,
    input  bus_req_ready,
    input  bus_resp_valid,
    input  bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid,
    input  bus_req_write,
    input  bus_req_addr,
    input  bus_req_wdata,
    input  bus_req_strobe,
    output bus_req_ready,
    output bus_resp_valid,
    output bus_resp_rdata
  );
endinterface

// File: rtl/multicycle_mem_bridge.sv
// Bridge between the multicycle controller's single-cycle memory strobes and a
// valid/ready memory bus. Each access becomes one bus transaction while the
// controller is stalled; data accesses get byte strobes, lane-replicated store
// data and sign/zero-extended load data. Illegal accesses never reach the bus
// and complete with a fault pulse.
//
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to abort a transaction that
// spends TIMEOUT_CYCLES cycles in REQ+RESP; it then completes with a fault and
// any late response is ignored. Without it, REQ and RESP wait indefinitely.
module multicycle_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic        inst_or_data,
  input  logic [31:0] pc,
  input  logic [31:0] data_address,
  input  logic [31:0] write_data,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        fault,
  multicycle_mem_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  logic        access;
  logic [31:0] req_address;
  logic        illegal;
  logic [3:0]  store_strobe;
  logic [31:0] store_wdata;
  logic [1:0]  lat_lane;
  logic [2:0]  lat_funct3;
  logic        lat_fetch;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [COUNT_WIDTH-1:0] timeout_count;
`endif

  // Pull the lane out of the response word and extend it as funct3 asks.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Stall the controller for the whole access except its completion cycle.
  always_comb begin
    access = mem_read_enable | mem_write_enable;
    stall  = access & (state != DONE);
  end

  // Decode the incoming access: address source, legality and store lane layout.
  // Stores size themselves from funct3[1:0], matching how alignment is checked.
  always_comb begin
    req_address = inst_or_data ? data_address : pc;
    illegal     = 1'b0;
    if (mem_read_enable && mem_write_enable) begin
      illegal = 1'b1;
    end else if (mem_write_enable && !inst_or_data) begin
      illegal = 1'b1;
    end else if (!inst_or_data) begin
      illegal = (pc[1:0] != 2'b00);
    end else begin
      case (funct3)
        3'b011, 3'b110, 3'b111: illegal = 1'b1;
        default: begin
          case (funct3[1:0])
            2'b01:   illegal = req_address[0];
            2'b10:   illegal = (req_address[1:0] != 2'b00);
            default: illegal = 1'b0;
          endcase
        end
      endcase
    end

    case (funct3[1:0])
      2'b00: begin
        store_strobe = 4'b0001 << req_address[1:0];
        store_wdata  = {4{write_data[7:0]}};
      end
      2'b01: begin
        store_strobe = 4'b0011 << {req_address[1], 1'b0};
        store_wdata  = {2{write_data[15:0]}};
      end
      default: begin
        store_strobe = 4'b1111;
        store_wdata  = write_data;
      end
    endcase
  end

  // Transaction FSM with all bus and completion outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      read_data          <= 32'd0;
      read_valid         <= 1'b0;
      fault              <= 1'b0;
      bus.bus_req_valid  <= 1'b0;
      bus.bus_req_write  <= 1'b0;
      bus.bus_req_addr   <= 32'd0;
      bus.bus_req_wdata  <= 32'd0;
      bus.bus_req_strobe <= 4'd0;
      lat_lane           <= 2'd0;
      lat_funct3         <= 3'd0;
      lat_fetch          <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      timeout_count      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          read_valid <= 1'b0;
          fault      <= 1'b0;
          if (access) begin
            lat_lane   <= req_address[1:0];
            lat_funct3 <= funct3;
            lat_fetch  <= !inst_or_data;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            timeout_count <= '0;
`endif
            if (illegal) begin
              state      <= DONE;
              read_valid <= 1'b1;
              fault      <= 1'b1;
              read_data  <= 32'd0;
            end else begin
              state              <= REQ;
              bus.bus_req_valid  <= 1'b1;
              bus.bus_req_write  <= mem_write_enable;
              bus.bus_req_addr   <= {req_address[31:2], 2'b00};
              bus.bus_req_strobe <= mem_write_enable ? store_strobe : 4'b1111;
              bus.bus_req_wdata  <= mem_write_enable ? store_wdata : 32'd0;
            end
          end
        end

        REQ: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
          timeout_count <= timeout_count + 1'b1;
`endif
          if (bus.bus_req_ready) begin
            bus.bus_req_valid <= 1'b0;
            if (bus.bus_req_write) begin
              state      <= DONE;
              read_valid <= 1'b1;
              read_data  <= 32'd0;
            end else begin
              state <= RESP;
            end
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (timeout_count == TIMEOUT_LAST) begin
            bus.bus_req_valid <= 1'b0;
            state             <= DONE;
            read_valid        <= 1'b1;
            fault             <= 1'b1;
            read_data         <= 32'd0;
          end
`endif
        end

        RESP: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
          timeout_count <= timeout_count + 1'b1;
`endif
          if (bus.bus_resp_valid) begin
            state      <= DONE;
            read_valid <= 1'b1;
            read_data  <= lat_fetch ? bus.bus_resp_rdata
                                    : extract_load(bus.bus_resp_rdata, lat_lane, lat_funct3);
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (timeout_count == TIMEOUT_LAST) begin
            state      <= DONE;
            read_valid <= 1'b1;
            fault      <= 1'b1;
            read_data  <= 32'd0;
          end
`endif
        end

        default: begin
          state      <= IDLE;
          read_valid <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_mem_bridge.sv
// Self-checking bench for multicycle_mem_bridge: a table of hand-computed
// vectors, hand-written reset and hang/timeout sequences, and randomized
// accesses checked against an arithmetic reference model.
module tb_multicycle_mem_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read_enable = 1'b0;
  logic        mem_write_enable = 1'b0;
  logic        inst_or_data = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] data_address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        stall;
  logic [31:0] read_data;
  logic        read_valid;
  logic        fault;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_mem_bridge_if bus_if();

  multicycle_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock),
    .reset(reset),
    .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .inst_or_data(inst_or_data),
    .pc(pc),
    .data_address(data_address),
    .write_data(write_data),
    .funct3(funct3),
    .stall(stall),
    .read_data(read_data),
    .read_valid(read_valid),
    .fault(fault),
    .bus(bus_if.master)
  );

  // Free-running core clock.
  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        iod;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          ready_delay;
    int          resp_delay;
    logic [31:0] rdata;
    logic        noise;
    logic        exp_fault;
    logic [31:0] exp_read_data;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strobe;
    logic [31:0] exp_wdata;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int          stall_cycles;
    int          handshakes;
    int          valid_cycles;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        write;
    logic        unstable;
    logic [31:0] read_data;
    logic        fault;
    logic        finished;
    logic        post_rv;
    logic [31:0] post_read_data;
  } obs_t;

  function automatic vec_t mk_vec(input logic rd, input logic wr, input logic iod,
                                  input logic [31:0] vpc, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  input int rdy, input int rsp, input logic [31:0] rdata,
                                  input logic noise, input logic ef, input logic [31:0] erd,
                                  input logic [31:0] ea, input logic [3:0] es,
                                  input logic [31:0] ew, input int est);
    vec_t v;
    v.rd = rd; v.wr = wr; v.iod = iod; v.pc = vpc; v.addr = addr; v.wdata = wd;
    v.f3 = f3; v.ready_delay = rdy; v.resp_delay = rsp; v.rdata = rdata; v.noise = noise;
    v.exp_fault = ef; v.exp_read_data = erd; v.exp_addr = ea; v.exp_strobe = es;
    v.exp_wdata = ew; v.exp_stall = est;
    return v;
  endfunction

  // Reference model: access size, alignment, lane mask and extension from plain arithmetic.
  function automatic vec_t with_expected(input vec_t v);
    vec_t        r;
    logic [31:0] a;
    logic [31:0] mask;
    logic [31:0] value;
    int          size;
    r = v;
    a = v.iod ? v.addr : v.pc;
    size = v.iod ? (1 << v.f3[1:0]) : 4;
    r.exp_fault = (v.rd && v.wr) || (v.wr && !v.iod) ||
                  (v.iod && (v.f3 == 3'd3 || v.f3 == 3'd6 || v.f3 == 3'd7)) ||
                  ((a % size) != 0);
    r.exp_addr = a - (a % 4);
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (r.exp_fault) begin
      r.exp_read_data = 32'd0;
      r.exp_strobe    = 4'd0;
      r.exp_wdata     = 32'd0;
      r.exp_stall     = 1;
    end else if (v.wr) begin
      r.exp_strobe    = 4'(((1 << size) - 1) << (a % 4));
      r.exp_wdata     = (v.wdata & mask) *
                        ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1);
      r.exp_read_data = 32'd0;
      r.exp_stall     = 2 + v.ready_delay;
    end else begin
      r.exp_strobe = 4'hF;
      r.exp_wdata  = 32'd0;
      if (!v.iod) begin
        value = v.rdata;
      end else begin
        value = (v.rdata >> (8 * (a % 4))) & mask;
        if (!v.f3[2] && size < 4 && value >= (32'd1 << (8 * size - 1)))
          value = value - (32'd1 << (8 * size));
      end
      r.exp_read_data = value;
      r.exp_stall     = 3 + v.ready_delay + v.resp_delay;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one controller access and act as the memory for it, recording what the DUT did.
  task automatic applyStimulus(input vec_t v, input int budget, output obs_t o);
    int   resp_wait;
    logic in_resp;
    logic seen;
    o = '{default: 0};
    resp_wait = 0;
    in_resp = 1'b0;
    seen = 1'b0;
    @(negedge clock);
    mem_read_enable  = v.rd;
    mem_write_enable = v.wr;
    inst_or_data     = v.iod;
    pc               = v.pc;
    data_address     = v.addr;
    write_data       = v.wdata;
    funct3           = v.f3;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (stall) o.stall_cycles++;
      bus_if.bus_req_ready  = 1'b0;
      bus_if.bus_resp_valid = 1'b0;
      bus_if.bus_resp_rdata = $urandom;
      if (in_resp) begin
        resp_wait++;
        if (resp_wait > v.resp_delay) begin
          bus_if.bus_resp_valid = 1'b1;
          bus_if.bus_resp_rdata = v.rdata;
          in_resp = 1'b0;
        end
      end else if (bus_if.bus_req_valid) begin
        o.valid_cycles++;
        if (!seen) begin
          seen     = 1'b1;
          o.addr   = bus_if.bus_req_addr;
          o.wdata  = bus_if.bus_req_wdata;
          o.strobe = bus_if.bus_req_strobe;
          o.write  = bus_if.bus_req_write;
        end else if (o.addr !== bus_if.bus_req_addr || o.wdata !== bus_if.bus_req_wdata ||
                     o.strobe !== bus_if.bus_req_strobe || o.write !== bus_if.bus_req_write) begin
          o.unstable = 1'b1;
        end
        if (o.valid_cycles > v.ready_delay) begin
          bus_if.bus_req_ready = 1'b1;
          o.handshakes++;
          if (!bus_if.bus_req_write) begin
            in_resp   = 1'b1;
            resp_wait = 0;
          end
          if (v.noise) begin
            bus_if.bus_resp_valid = 1'b1;
            bus_if.bus_resp_rdata = ~v.rdata;
          end
        end
      end
      if (read_valid) begin
        o.read_data = read_data;
        o.fault     = fault;
        o.finished  = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    mem_read_enable       = 1'b0;
    mem_write_enable      = 1'b0;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    #1;
    o.post_rv        = read_valid;
    o.post_read_data = read_data;
  endtask

  task automatic runVector(input string tag, input vec_t v);
    obs_t o;
    applyStimulus(v, 200, o);
    checkOutput({tag, ".completed"}, 32'(o.finished), 32'd1);
    checkOutput({tag, ".stall_cycles"}, o.stall_cycles, v.exp_stall);
    checkOutput({tag, ".fault"}, 32'(o.fault), 32'(v.exp_fault));
    checkOutput({tag, ".read_data"}, o.read_data, v.exp_read_data);
    checkOutput({tag, ".read_valid_pulse"}, 32'(o.post_rv), 32'd0);
    checkOutput({tag, ".read_data_hold"}, o.post_read_data, v.exp_read_data);
    checkOutput({tag, ".handshakes"}, o.handshakes, v.exp_fault ? 0 : 1);
    if (v.exp_fault) begin
      checkOutput({tag, ".no_req_valid"}, o.valid_cycles, 32'd0);
    end else begin
      checkOutput({tag, ".addr"}, o.addr, v.exp_addr);
      checkOutput({tag, ".strobe"}, 32'(o.strobe), 32'(v.exp_strobe));
      checkOutput({tag, ".write"}, 32'(o.write), 32'(v.wr));
      checkOutput({tag, ".req_stable"}, 32'(o.unstable), 32'd0);
      if (v.wr) checkOutput({tag, ".wdata"}, o.wdata, v.exp_wdata);
    end
  endtask

  vec_t table_vecs[17];

  // Main test sequence.
  initial begin
    vec_t v;
    obs_t o;
    int   kind;
    logic [31:0] low;

    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_rdata = 32'd0;

    table_vecs[0]  = mk_vec(1,0,0, 32'h100,0,0,3'b010, 0,1, 32'hDEADBEEF,0, 0,32'hDEADBEEF,32'h100,4'hF,0, 4);
    table_vecs[1]  = mk_vec(0,1,1, 0,32'h203,32'hA5,3'b000, 3,0, 0,0, 0,0,32'h200,4'b1000,32'hA5A5A5A5, 5);
    table_vecs[2]  = mk_vec(1,0,1, 0,32'h1,0,3'b000, 0,0, 32'h00008000,1, 0,32'hFFFFFF80,0,4'hF,0, 3);
    table_vecs[3]  = mk_vec(1,0,1, 0,32'h1,0,3'b100, 0,0, 32'h00008000,0, 0,32'h00000080,0,4'hF,0, 3);
    table_vecs[4]  = mk_vec(1,0,1, 0,32'h2,0,3'b001, 0,0, 32'h80000000,0, 0,32'hFFFF8000,0,4'hF,0, 3);
    table_vecs[5]  = mk_vec(1,0,1, 0,32'h2,0,3'b101, 0,0, 32'h80000000,0, 0,32'h00008000,0,4'hF,0, 3);
    table_vecs[6]  = mk_vec(1,0,1, 0,32'h6,0,3'b010, 0,0, 32'h11111111,0, 1,0,0,0,0, 1);
    table_vecs[7]  = mk_vec(1,0,1, 0,32'h8,0,3'b011, 0,0, 32'h11111111,0, 1,0,0,0,0, 1);
    table_vecs[8]  = mk_vec(1,1,1, 0,32'h8,32'h5,3'b010, 0,0, 32'h11111111,0, 1,0,0,0,0, 1);
    table_vecs[9]  = mk_vec(0,1,0, 32'h100,0,32'h5,3'b010, 0,0, 0,0, 1,0,0,0,0, 1);
    table_vecs[10] = mk_vec(1,0,0, 32'h102,0,0,3'b010, 0,0, 32'h22222222,0, 1,0,0,0,0, 1);
    table_vecs[11] = mk_vec(0,1,1, 0,32'h12,32'h1234BEEF,3'b001, 0,0, 0,0, 0,0,32'h10,4'b1100,32'hBEEFBEEF, 2);
    table_vecs[12] = mk_vec(0,1,1, 0,32'h20,32'hCAFEF00D,3'b010, 0,0, 0,0, 0,0,32'h20,4'hF,32'hCAFEF00D, 2);
    table_vecs[13] = mk_vec(1,0,1, 0,32'h44,0,3'b010, 1,2, 32'h12345678,1, 0,32'h12345678,32'h44,4'hF,0, 6);
    table_vecs[14] = mk_vec(1,0,1, 0,32'h3,0,3'b000, 0,0, 32'h7F000000,0, 0,32'h0000007F,0,4'hF,0, 3);
    table_vecs[15] = mk_vec(0,1,1, 0,32'h201,32'h5A,3'b000, 0,0, 0,0, 0,0,32'h200,4'b0010,32'h5A5A5A5A, 2);
    table_vecs[16] = mk_vec(0,1,1, 0,32'h11,32'h77,3'b001, 0,0, 0,0, 1,0,0,0,0, 1);

    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset.stall", 32'(stall), 32'd0);
    checkOutput("reset.read_valid", 32'(read_valid), 32'd0);
    checkOutput("reset.fault", 32'(fault), 32'd0);
    checkOutput("reset.req_valid", 32'(bus_if.bus_req_valid), 32'd0);
    checkOutput("reset.req_write", 32'(bus_if.bus_req_write), 32'd0);
    checkOutput("reset.read_data", read_data, 32'd0);
    checkOutput("reset.req_addr", bus_if.bus_req_addr, 32'd0);
    checkOutput("reset.req_wdata", bus_if.bus_req_wdata, 32'd0);
    checkOutput("reset.req_strobe", 32'(bus_if.bus_req_strobe), 32'd0);
    reset = 1'b0;

    foreach (table_vecs[i])
      runVector($sformatf("vec%0d", i), table_vecs[i]);

    // Reset while waiting for a read response; a later response must be ignored.
    runVector("pre_reset", table_vecs[0]);
    @(negedge clock);
    mem_read_enable = 1'b1; inst_or_data = 1'b1; funct3 = 3'b010; data_address = 32'h40;
    bus_if.bus_req_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus_if.bus_req_ready = 1'b0;
    #1;
    checkOutput("rst.in_resp_stall", 32'(stall), 32'd1);
    checkOutput("rst.in_resp_req_valid", 32'(bus_if.bus_req_valid), 32'd0);
    reset = 1'b1;
    mem_read_enable = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("rst.stall", 32'(stall), 32'd0);
    checkOutput("rst.read_valid", 32'(read_valid), 32'd0);
    checkOutput("rst.read_data", read_data, 32'd0);
    checkOutput("rst.req_addr", bus_if.bus_req_addr, 32'd0);
    reset = 1'b0;
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_rdata = 32'h0BAD_C0DE;
    @(negedge clock);
    bus_if.bus_resp_valid = 1'b0;
    #1;
    checkOutput("rst.late_resp_valid", 32'(read_valid), 32'd0);
    checkOutput("rst.late_resp_data", read_data, 32'd0);
    @(negedge clock);
    #1;
    checkOutput("rst.late_resp_valid2", 32'(read_valid), 32'd0);
    runVector("post_reset", table_vecs[13]);

    // Memory that never accepts the request.
    v = mk_vec(1,0,1, 0,32'h80,0,3'b010, 100000,0, 32'h1,0, 0,0,0,0,0, 0);
`ifdef MEM_BRIDGE_TIMEOUT_EN
    applyStimulus(v, 40, o);
    checkOutput("timeout.completed", 32'(o.finished), 32'd1);
    checkOutput("timeout.req_cycles", o.valid_cycles, 32'd8);
    checkOutput("timeout.stall_cycles", o.stall_cycles, 32'd9);
    checkOutput("timeout.handshakes", o.handshakes, 32'd0);
    checkOutput("timeout.fault", 32'(o.fault), 32'd1);
    checkOutput("timeout.read_data", o.read_data, 32'd0);
    checkOutput("timeout.req_valid_dropped", 32'(bus_if.bus_req_valid), 32'd0);
    @(negedge clock);
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_rdata = 32'h1234_0000;
    @(negedge clock);
    bus_if.bus_resp_valid = 1'b0;
    #1;
    checkOutput("timeout.late_resp_ignored", 32'(read_valid), 32'd0);
`else
    applyStimulus(v, 100, o);
    checkOutput("hang.not_completed", 32'(o.finished), 32'd0);
    checkOutput("hang.stall_cycles", o.stall_cycles, 32'd100);
    checkOutput("hang.req_cycles", o.valid_cycles, 32'd99);
    checkOutput("hang.handshakes", o.handshakes, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("hang.req_valid_after_reset", 32'(bus_if.bus_req_valid), 32'd0);
`endif
    runVector("recovery", table_vecs[1]);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      low  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : 32'd0;
      v.pc          = ($urandom & 32'hFFFF_FFFC) | low;
      v.addr        = ($urandom & 32'hFFFF_FFFC) | low;
      v.wdata       = $urandom;
      v.rdata       = $urandom;
      v.f3          = 3'($urandom_range(0, 7));
      v.ready_delay = $urandom_range(0, 2);
      v.resp_delay  = $urandom_range(0, 2);
      v.noise       = 1'($urandom_range(0, 1));
      if (kind <= 1) begin
        v.rd = 1'b1; v.wr = 1'b0; v.iod = 1'b0;
      end else if (kind <= 5) begin
        v.rd = 1'b1; v.wr = 1'b0; v.iod = 1'b1;
      end else if (kind <= 8) begin
        v.rd = 1'b0; v.wr = 1'b1; v.iod = 1'b1;
        v.f3 = 3'($urandom_range(0, 2));
      end else begin
        v.rd = 1'($urandom_range(0, 1)); v.wr = 1'b1; v.iod = 1'($urandom_range(0, 1));
      end
      v = with_expected(v);
      runVector($sformatf("rand%0d", n), v);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
